// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked
// shift of one command byte with odd parity, then acknowledge or timeout.
`timescale 1ns/1ps
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] command,
  input  logic       send_command,
  inout  logic       PS2_CLK,
  inout  logic       PS2_DAT,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_REQUEST, S_WAIT_FIRST, S_SHIFT,
    S_WAIT_ACK, S_WAIT_RELEASE, S_DONE, S_ERROR
  } state_t;

  localparam logic [19:0] INH_LAST   = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] START_LAST = 20'(START_TIMEOUT - 1);
  localparam logic [19:0] XFER_LAST  = 20'(XFER_TIMEOUT - 1);

  state_t      r_state;
  logic [8:0]  r_shift;
  logic [3:0]  r_count;
  logic [19:0] r_timer;
  logic        r_clkLow, r_datLow;
  logic        r_busy, r_sent, r_err;
  logic        r_clkMeta, r_clkSync, r_clkPrev;
  logic        r_datMeta, r_datSync;

  logic        w_fe;
  logic        w_xferExpired;
  logic [19:0] w_timerNext;

  // The block only ever pulls a line low; the pull-up supplies the 1.
  assign PS2_CLK = r_clkLow ? 1'b0 : 1'bz;
  assign PS2_DAT = r_datLow ? 1'b0 : 1'bz;

  assign busy                          = r_busy;
  assign command_was_sent              = r_sent;
  assign error_communication_timed_out = r_err;

  assign w_fe          = r_clkPrev & ~r_clkSync;
  assign w_xferExpired = (r_timer == XFER_LAST);
  assign w_timerNext   = (r_timer == 20'hFFFFF) ? r_timer : r_timer + 20'd1;

  // Synchronizers reset to the idle-high line level so no false edge follows reset.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_clkMeta <= 1'b1;
      r_clkSync <= 1'b1;
      r_clkPrev <= 1'b1;
      r_datMeta <= 1'b1;
      r_datSync <= 1'b1;
    end else begin
      r_clkMeta <= PS2_CLK;
      r_clkSync <= r_clkMeta;
      r_clkPrev <= r_clkSync;
      r_datMeta <= PS2_DAT;
      r_datSync <= r_datMeta;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_shift  <= 9'd0;
      r_count  <= 4'd0;
      r_timer  <= 20'd0;
      r_clkLow <= 1'b0;
      r_datLow <= 1'b0;
      r_busy   <= 1'b0;
      r_sent   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_sent <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clkLow <= 1'b0;
          r_datLow <= 1'b0;
          if (send_command) begin
            r_shift  <= {~^command, command};
            r_count  <= 4'd0;
            r_timer  <= 20'd0;
            r_clkLow <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_timer == INH_LAST) begin
            r_datLow <= 1'b1;
            r_timer  <= 20'd0;
            r_state  <= S_REQUEST;
          end else begin
            r_timer <= w_timerNext;
          end
        end
        S_REQUEST: begin
          r_clkLow <= 1'b0;
          r_timer  <= 20'd0;
          r_state  <= S_WAIT_FIRST;
        end
        // Timeout is tested before the edge so a coincident edge still errors out.
        S_WAIT_FIRST: begin
          if (r_timer == START_LAST) begin
            r_err    <= 1'b1;
            r_clkLow <= 1'b0;
            r_datLow <= 1'b0;
            r_timer  <= 20'd0;
            r_state  <= S_ERROR;
          end else if (w_fe) begin
            r_datLow <= ~r_shift[0];
            r_count  <= 4'd1;
            r_timer  <= 20'd0;
            r_state  <= S_SHIFT;
          end else begin
            r_timer <= w_timerNext;
          end
        end
        S_SHIFT: begin
          if (w_xferExpired) begin
            r_err    <= 1'b1;
            r_clkLow <= 1'b0;
            r_datLow <= 1'b0;
            r_timer  <= 20'd0;
            r_state  <= S_ERROR;
          end else begin
            r_timer <= w_timerNext;
            if (w_fe) begin
              r_count <= r_count + 4'd1;
              if (r_count == 4'd9) begin
                r_datLow <= 1'b0;
                r_state  <= S_WAIT_ACK;
              end else begin
                r_datLow <= ~r_shift[r_count];
              end
            end
          end
        end
        S_WAIT_ACK: begin
          if (w_xferExpired || (w_fe && r_datSync)) begin
            r_err    <= 1'b1;
            r_clkLow <= 1'b0;
            r_datLow <= 1'b0;
            r_timer  <= 20'd0;
            r_state  <= S_ERROR;
          end else begin
            r_timer <= w_timerNext;
            if (w_fe) r_state <= S_WAIT_RELEASE;
          end
        end
        S_WAIT_RELEASE: begin
          if (w_xferExpired) begin
            r_err    <= 1'b1;
            r_timer  <= 20'd0;
            r_state  <= S_ERROR;
          end else if (r_clkSync && r_datSync) begin
            r_sent  <= 1'b1;
            r_timer <= 20'd0;
            r_state <= S_DONE;
          end else begin
            r_timer <= w_timerNext;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERROR: begin
          r_clkLow <= 1'b0;
          r_datLow <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_clkLow <= 1'b0;
          r_datLow <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench for ps2_command_tx: a behavioural keyboard clocks the byte
// out, and results are compared against hand-derived frames and timings.
`timescale 1ns/1ps
module tb_ps2_command_tx;

  localparam int INH  = 50;
  localparam int STO  = 600;
  localparam int XTO  = 1000;
  localparam int HALF = 20;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] command = 8'h00;
  logic       send_command = 1'b0;
  logic       busy, command_was_sent, error_communication_timed_out;
  wire        ps2Clk, ps2Dat;
  logic       devClkLow = 1'b0;
  logic       devDatLow = 1'b0;

  int total = 0;
  int bad = 0;
  int cycleCnt = 0;
  int sentCnt = 0;
  int errCnt = 0;
  int errAt = 0;
  int firstFallCycle = 0;

  pullup (ps2Clk);
  pullup (ps2Dat);
  assign ps2Clk = devClkLow ? 1'b0 : 1'bz;
  assign ps2Dat = devDatLow ? 1'b0 : 1'bz;

  ps2_command_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT(STO),
    .XFER_TIMEOUT(XTO)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .command(command),
    .send_command(send_command),
    .PS2_CLK(ps2Clk),
    .PS2_DAT(ps2Dat),
    .busy(busy),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cycleCnt++;

  always @(negedge CLOCK_50) begin
    if (command_was_sent === 1'b1) sentCnt++;
    if (error_communication_timed_out === 1'b1) begin
      errCnt++;
      errAt = cycleCnt;
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got hang expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd);
    @(negedge CLOCK_50);
    command = cmd;
    send_command = 1'b1;
    @(negedge CLOCK_50);
    send_command = 1'b0;
  endtask

  // Counts clock-low and data-lead cycles until the request (clk released, data low) appears.
  task automatic waitRelease(output bit ok, output int lowC, output int lead);
    ok = 1'b0;
    lowC = 0;
    lead = 0;
    for (int i = 0; i < INH + 100; i++) begin
      if (ps2Clk === 1'b1 && ps2Dat === 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (ps2Clk === 1'b0) lowC++;
      if (ps2Clk === 1'b0 && ps2Dat === 1'b0) lead++;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic deviceTransfer(input int nEdges, input bit ack, output logic [9:0] captured,
                                output bit ok, output int lowC, output int lead);
    captured = 10'd0;
    devDatLow = 1'b0;
    waitRelease(ok, lowC, lead);
    if (ok) begin
      repeat (10) @(negedge CLOCK_50);
      for (int i = 0; i < nEdges; i++) begin
        if (i == 10) devDatLow = ack;
        repeat (HALF) @(negedge CLOCK_50);
        devClkLow = 1'b1;
        if (i == 0) firstFallCycle = cycleCnt;
        repeat (HALF - 2) @(negedge CLOCK_50);
        if (i < 10) captured[i] = ps2Dat;
        repeat (2) @(negedge CLOCK_50);
        devClkLow = 1'b0;
      end
      if (nEdges == 11) begin
        repeat (HALF) @(negedge CLOCK_50);
        devDatLow = 1'b0;
      end
    end
  endtask

  task automatic waitSuccess(output bit seen, output bit busyAt, output bit busyAfter, output bit pulseAfter);
    seen = 1'b0;
    busyAt = 1'b0;
    busyAfter = 1'b1;
    pulseAfter = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK_50);
      if (command_was_sent === 1'b1) begin
        seen = 1'b1;
        busyAt = busy;
        @(negedge CLOCK_50);
        busyAfter = busy;
        pulseAfter = command_was_sent;
        break;
      end
    end
  endtask

  initial begin
    logic [9:0] bits;
    bit ok, seen, bAt, bAfter, pAfter;
    int lowC, lead, sBase, eBase, n, diff;

    repeat (3) @(negedge CLOCK_50);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstSent", command_was_sent, 0);
    checkOutput("rstErr", error_communication_timed_out, 0);
    checkOutput("rstClkLine", ps2Clk, 1);
    checkOutput("rstDatLine", ps2Dat, 1);
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    $display("[TB] send 0xF4 with ack");
    sBase = sentCnt; eBase = errCnt;
    applyStimulus(8'hF4);
    checkOutput("f4BusyRise", busy, 1);
    checkOutput("f4ClkLowAtInhibit", ps2Clk, 0);
    deviceTransfer(11, 1'b1, bits, ok, lowC, lead);
    checkOutput("f4Request", ok, 1);
    checkOutput("f4ClkLowCycles", lowC, INH + 1);
    checkOutput("f4DatLead", lead, 1);
    checkOutput("f4Frame", bits, 10'h2F4);
    waitSuccess(seen, bAt, bAfter, pAfter);
    checkOutput("f4Sent", seen, 1);
    checkOutput("f4BusyAtPulse", bAt, 1);
    checkOutput("f4BusyFall", bAfter, 0);
    checkOutput("f4PulseWidth", pAfter, 0);
    checkOutput("f4SentCount", sentCnt - sBase, 1);
    checkOutput("f4ErrCount", errCnt - eBase, 0);

    $display("[TB] send 0xED, with an ignored 0x00 request while busy");
    repeat (5) @(negedge CLOCK_50);
    sBase = sentCnt; eBase = errCnt;
    applyStimulus(8'hED);
    command = 8'h00;
    send_command = 1'b1;
    @(negedge CLOCK_50);
    send_command = 1'b0;
    deviceTransfer(11, 1'b1, bits, ok, lowC, lead);
    checkOutput("edRequest", ok, 1);
    checkOutput("edFrame", bits, 10'h3ED);
    waitSuccess(seen, bAt, bAfter, pAfter);
    checkOutput("edSent", seen, 1);
    repeat (30) @(negedge CLOCK_50);
    checkOutput("edNoQueuedSend", busy, 0);
    checkOutput("edSentCount", sentCnt - sBase, 1);
    checkOutput("edErrCount", errCnt - eBase, 0);

    $display("[TB] device never clocks");
    sBase = sentCnt; eBase = errCnt;
    applyStimulus(8'hF4);
    waitRelease(ok, lowC, lead);
    checkOutput("stRequest", ok, 1);
    n = 0;
    for (int k = 0; k < STO + 50; k++) begin
      @(negedge CLOCK_50);
      n++;
      if (error_communication_timed_out === 1'b1) break;
    end
    checkOutput("startTimeoutCycles", n, STO);
    checkOutput("stClkReleased", ps2Clk, 1);
    checkOutput("stDatReleased", ps2Dat, 1);
    repeat (5) @(negedge CLOCK_50);
    checkOutput("stErrCount", errCnt - eBase, 1);
    checkOutput("stSentCount", sentCnt - sBase, 0);
    checkOutput("stBusyLow", busy, 0);

    $display("[TB] send 0xFF, device withholds ack");
    sBase = sentCnt; eBase = errCnt;
    applyStimulus(8'hFF);
    deviceTransfer(11, 1'b0, bits, ok, lowC, lead);
    checkOutput("ffFrame", bits, 10'h3FF);
    repeat (20) @(negedge CLOCK_50);
    checkOutput("ffErrCount", errCnt - eBase, 1);
    checkOutput("ffSentCount", sentCnt - sBase, 0);
    checkOutput("ffBusyLow", busy, 0);

    $display("[TB] device stops after 5 edges, then retry");
    sBase = sentCnt; eBase = errCnt;
    applyStimulus(8'h55);
    deviceTransfer(5, 1'b1, bits, ok, lowC, lead);
    for (int k = 0; k < XTO + 100; k++) begin
      if (errCnt != eBase) break;
      @(negedge CLOCK_50);
    end
    checkOutput("xferErrCount", errCnt - eBase, 1);
    diff = errAt - firstFallCycle;
    checkOutput("xferTimeoutWindow", (diff >= XTO && diff <= XTO + 5) ? 1 : 0, 1);
    checkOutput("xferSentCount", sentCnt - sBase, 0);
    repeat (3) @(negedge CLOCK_50);
    applyStimulus(8'hF4);
    deviceTransfer(11, 1'b1, bits, ok, lowC, lead);
    checkOutput("retryFrame", bits, 10'h2F4);
    waitSuccess(seen, bAt, bAfter, pAfter);
    checkOutput("retrySent", seen, 1);

    $display("[TB] async reset in the middle of the shift");
    repeat (5) @(negedge CLOCK_50);
    applyStimulus(8'hED);
    deviceTransfer(5, 1'b1, bits, ok, lowC, lead);
    checkOutput("midBit4Driven", ps2Dat, 0);
    checkOutput("midBusy", busy, 1);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("midRstClk", ps2Clk, 1);
    checkOutput("midRstDat", ps2Dat, 1);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstSent", command_was_sent, 0);
    checkOutput("midRstErr", error_communication_timed_out, 0);
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
